// File: rtl/serial_operand_loader_pkg.sv
// Shared types and constants for the serial operand loader: FSM state encoding,
// framing bit values and the frame-length helper.
package operand_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShiftA,
    StShiftB,
    StParity,
    StStop
  } loader_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Clocks per frame: start + A + B + optional parity + stop.
  function automatic int unsigned FRAME_LEN(input int unsigned data_w,
                                            input int unsigned parity_en);
    return 2 + 2 * data_w + parity_en;
  endfunction

endpackage

// File: rtl/serial_operand_loader_if.sv
// Serial-in / parallel-operand-out bundle; the loader is the slave, the feeding
// and consuming logic together act as master.
interface serial_operand_loader_if #(
  parameter int unsigned DATA_W = 4
);
  logic              d_in;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic              frame_err;
  logic              overflow;
  logic              busy;

  modport master (
    output d_in, op_ready,
    input  op_a, op_b, op_valid, frame_err, overflow, busy
  );

  modport slave (
    input  d_in, op_ready,
    output op_a, op_b, op_valid, frame_err, overflow, busy
  );
endinterface

// File: rtl/serial_operand_loader_hold_slot.sv
// One-entry valid/ready holding register for a decoded A/B pair; a load that
// arrives while full and not being drained is dropped and flagged.
module operand_hold_slot #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              o_valid,
  output logic              o_overflow
);

  logic [DATA_W-1:0] r_a, r_b;
  logic              r_valid, r_overflow;
  logic              w_accept;

  // A pop in the same cycle frees the slot for the incoming pair.
  assign w_accept = i_load & (~r_valid | i_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_load & r_valid & ~i_ready;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_valid <= 1'b1;
      end else if (r_valid & i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/serial_operand_loader.sv
// Deserialises framed A/B operand pairs from a 1-bit line, checks parity and
// stop bit, and hands good pairs to the datapath through a one-entry slot.
module serial_operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  serial_operand_loader_if.slave bus
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  loader_state_t     r_state, w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_par_err, r_frame_err;
  logic              w_cnt_last, w_start, w_shift_a, w_shift_b, w_chk_par, w_chk_stop;
  logic              w_busy, w_commit;
  logic [DATA_W-1:0] w_slot_a, w_slot_b;
  logic              w_slot_valid, w_slot_ovf;

  assign w_cnt_last = (r_cnt == CntLast);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (bus.d_in == START_BIT) w_state_d = StShiftA;
      StShiftA: if (w_cnt_last) w_state_d = StShiftB;
      StShiftB: if (w_cnt_last) w_state_d = PARITY_EN ? StParity : StStop;
      StParity: w_state_d = StStop;
      StStop:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_start    = 1'b0;
    w_shift_a  = 1'b0;
    w_shift_b  = 1'b0;
    w_chk_par  = 1'b0;
    w_chk_stop = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy  = 1'b0;
        w_start = (bus.d_in == START_BIT);
      end
      StShiftA: w_shift_a  = 1'b1;
      StShiftB: w_shift_b  = 1'b1;
      StParity: w_chk_par  = 1'b1;
      StStop:   w_chk_stop = 1'b1;
      default:  w_busy     = 1'b0;
    endcase
  end

  // A stop-state 1 only flags the frame; the FSM still returns to idle.
  assign w_commit = w_chk_stop & (bus.d_in == STOP_BIT) & ~r_par_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_chk_stop & ((bus.d_in != STOP_BIT) | r_par_err);
      if (w_start) begin
        r_cnt     <= '0;
        r_par_err <= 1'b0;
      end
      if (w_shift_a | w_shift_b) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_shift_a) r_a <= {r_a[DATA_W-2:0], bus.d_in};
      if (w_shift_b) r_b <= {r_b[DATA_W-2:0], bus.d_in};
      // Even parity: any odd total over A, B and the parity bit is a mismatch.
      if (w_chk_par) r_par_err <= ^{r_a, r_b, bus.d_in};
    end
  end

  operand_hold_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_commit),
    .i_a        (r_a),
    .i_b        (r_b),
    .i_ready    (bus.op_ready),
    .o_a        (w_slot_a),
    .o_b        (w_slot_b),
    .o_valid    (w_slot_valid),
    .o_overflow (w_slot_ovf)
  );

  assign bus.op_a      = w_slot_a;
  assign bus.op_b      = w_slot_b;
  assign bus.op_valid  = w_slot_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = w_slot_ovf;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Scoreboard bench for serial_operand_loader: directed frames push expected
// events; a negedge monitor pops and compares every pair, error and overflow.
module tb_serial_operand_loader;
  import operand_loader_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned FL = FRAME_LEN(DW, 1);

  typedef enum int {EvPair, EvErr, EvOvf} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            cyc;
  } ev_t;

  ev_t           exp_q[$];
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            noise = 1'b0;
  logic          pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [DW-1:0] held_a = '0, held_b = '0;

  serial_operand_loader_if #(.DATA_W(DW)) bus ();

  serial_operand_loader #(
    .DATA_W    (DW),
    .PARITY_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.d_in = b;
    tick();
  endtask

  task automatic idle(input int n);
    bus.d_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic par,
                            input logic stp, input ev_kind_t kind, input logic rdy_at_stop);
    ev_t e;
    send_bit(START_BIT);
    check("busy_after_start", bus.busy, 1);
    for (int i = DW - 1; i >= 0; i--) send_bit(a[i]);
    for (int i = DW - 1; i >= 0; i--) send_bit(b[i]);
    send_bit(par);
    bus.op_ready = rdy_at_stop;
    send_bit(stp);
    bus.op_ready = 1'b0;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic pop();
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check("valid_after_pop", bus.op_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_a"}, bus.op_a, 0);
    check({tag, "_op_b"}, bus.op_b, 0);
    check({tag, "_op_valid"}, bus.op_valid, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, required none (cycle %0d)", int'(k), cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(k), int'(e.kind));
    check("event_cycle", cyc, e.cyc);
    if (k == EvPair) begin
      check("pair_op_a", a, e.a);
      check("pair_op_b", b, e.b);
      held_a = e.a;
      held_b = e.b;
    end
  endtask

  // Monitor: a new pair shows as valid with the slot previously empty or drained.
  initial begin
    forever begin
      @(negedge clk);
      if (!prst) begin
        check("err_ovf_exclusive", bus.frame_err & bus.overflow, 0);
        if (!noise) begin
          if (pv && !pr) begin
            check("hold_valid", bus.op_valid, 1);
            check("hold_op_a", bus.op_a, held_a);
            check("hold_op_b", bus.op_b, held_b);
          end
          if (bus.frame_err) expect_ev(EvErr, '0, '0);
          if (bus.overflow) expect_ev(EvOvf, '0, '0);
          if (bus.op_valid && (!pv || pr)) expect_ev(EvPair, bus.op_a, bus.op_b);
        end
      end
      pv   = bus.op_valid;
      pr   = bus.op_ready;
      prst = rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    bus.d_in     = 1'b0;
    bus.op_ready = 1'b0;
    rst          = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Good frame, then a single-cycle pop.
    send_frame(4'b1011, 4'b0110, 1'b1, 1'b0, EvPair, 1'b0);
    idle(2);
    pop();

    // A and B hold three ones, so the even-parity bit should be 1; 0 is the error.
    send_frame(4'b1010, 4'b0100, 1'b0, 1'b0, EvErr, 1'b0);
    idle(1);
    check("valid_after_parity_err", bus.op_valid, 0);
    send_frame(4'b0011, 4'b0101, 1'b0, 1'b0, EvPair, 1'b0);
    idle(1);
    pop();

    // Bad stop bit followed immediately by a good frame.
    send_frame(4'b1000, 4'b1110, 1'b0, 1'b1, EvErr, 1'b0);
    send_frame(4'b1111, 4'b0010, 1'b1, 1'b0, EvPair, 1'b0);
    idle(1);
    pop();

    // Overflow with the slot full, then a commit coincident with a pop.
    send_frame(4'b0001, 4'b0010, 1'b0, 1'b0, EvPair, 1'b0);
    send_frame(4'b0100, 4'b1000, 1'b0, 1'b0, EvOvf, 1'b0);
    idle(1);
    check("ovf_keeps_valid", bus.op_valid, 1);
    check("ovf_keeps_a", bus.op_a, 4'b0001);
    check("ovf_keeps_b", bus.op_b, 4'b0010);
    send_frame(4'b1100, 4'b0011, 1'b0, 1'b0, EvPair, 1'b1);
    check("replace_valid", bus.op_valid, 1);
    check("replace_a", bus.op_a, 4'b1100);
    check("replace_b", bus.op_b, 4'b0011);

    // Reset after the 5th bit of a frame, with a pair still held.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst      = 1'b1;
    bus.d_in = 1'b0;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    send_frame(4'b1001, 4'b0111, 1'b1, 1'b0, EvPair, 1'b0);
    idle(1);
    pop();

    // Random line noise with the slot drained, then a known frame.
    noise        = 1'b1;
    bus.op_ready = 1'b1;
    for (int i = 0; i < 50; i++) send_bit(1'($urandom_range(0, 1)));
    idle(FL + 3);
    bus.op_ready = 1'b0;
    noise        = 1'b0;
    check("busy_after_flush", bus.busy, 0);
    send_frame(4'b0101, 4'b1010, 1'b0, 1'b0, EvPair, 1'b0);
    idle(2);
    pop();
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
